// File: rtl/fpga_config_loader.sv
// fpga_config_loader: assembles streamed bitstream words into frames, strobes each frame
// into the fabric, then releases ff_en and finally rdy after the settle delays.
module fpga_config_loader #(
  parameter int FRAME_W    = 384,
  parameter int NUM_FRAMES = 267,
  parameter int WORD_W     = 32,
  parameter int SETTLE_CYC = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_W-1:0]     word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [FRAME_W-1:0]    configs_in,
  output logic [NUM_FRAMES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy
);
  localparam int WPF = FRAME_W / WORD_W;
  localparam int WCW = WPF > 1 ? $clog2(WPF) : 1;
  localparam int FIW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int SCW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, SETTLE_FF, SETTLE_RDY, DONE} state_t;
  state_t         state;
  logic [WCW-1:0] wcnt;
  logic [FIW-1:0] fidx;
  logic [SCW-1:0] scnt;
  assign word_ready = state == LOAD;
  assign busy       = state != IDLE && state != DONE;
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      fidx       <= '0;
      scnt       <= '0;
      configs_in <= '0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
    end else begin
      configs_en <= '0;
      case (state)
        IDLE, DONE: if (start) begin
          state      <= LOAD;
          wcnt       <= '0;
          fidx       <= '0;
          configs_in <= '0;
          ff_en      <= 1'b0;
          rdy        <= 1'b0;
        end
        LOAD: if (word_valid) begin
          configs_in[wcnt*WORD_W +: WORD_W] <= word_in;
          wcnt <= wcnt == WCW'(WPF-1) ? '0 : wcnt + 1'b1;
          // strobe is raised on the same edge that accepts the frame's last word
          if (wcnt == WCW'(WPF-1)) begin
            state      <= WRITE;
            configs_en <= NUM_FRAMES'(1) << fidx;
          end
        end
        WRITE: if (fidx == FIW'(NUM_FRAMES-1)) begin
          state <= SETTLE_FF;
          scnt  <= SCW'(SETTLE_CYC-1);
        end else begin
          fidx  <= fidx + 1'b1;
          state <= LOAD;
        end
        SETTLE_FF: if (scnt == '0) begin
          ff_en <= 1'b1;
          scnt  <= SCW'(SETTLE_CYC-1);
          state <= SETTLE_RDY;
        end else scnt <= scnt - 1'b1;
        SETTLE_RDY: if (scnt == '0) begin
          rdy   <= 1'b1;
          state <= DONE;
        end else scnt <= scnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
